v_merge_issue: RTL and testbench

Issue-side sequencer for the byte-mask vector merge pipeline. It accepts one merge command (destination beat address, vl, SEW) and then a stream of operand beats (vec0, vec1, per-element mask bits). For each beat it generates the address, the byte-granular select mask and the tail byte-enable that the merge pipeline consumes. It sits between the vector register-file read port and the merge unit, and splits each vector operation into DATA_WIDTH-wide beats.

---
 rtl/v_merge_pkg.sv | 22 ++
 rtl/v_mask_expand.sv | 27 ++
 rtl/v_merge_issue.sv | 118 +++++++++++
 tb/tb_v_merge_issue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_merge_pkg.sv
// Shared types and helpers for the byte-mask vector merge path.
// Used by the issue sequencer and by the mask expander.
package v_merge_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Elements per beat for a given element width.
  function automatic int unsigned epb(input sew_t sew, input int unsigned mask_width);
    return mask_width >> sew;
  endfunction

endpackage

// File: rtl/v_mask_expand.sv
// Expands per-element mask bits into byte-granular select mask and byte enable.
// Elements at or beyond n are tail: byte enable 0 and select forced to 0.
module v_mask_expand
  import v_merge_pkg::*;
#(
  parameter int MASK_WIDTH = 8,
  parameter int CNT_W      = $clog2(MASK_WIDTH) + 1
) (
  input  logic [MASK_WIDTH-1:0] emask,
  input  sew_t                  sew,
  input  logic [CNT_W-1:0]      n,
  output logic [MASK_WIDTH-1:0] byte_mask,
  output logic [MASK_WIDTH-1:0] byte_en
);

  always_comb begin
    byte_mask = '0;
    byte_en   = '0;
    for (int b = 0; b < MASK_WIDTH; b++) begin
      if ((b >> sew) < int'(n)) begin
        byte_en[b]   = 1'b1;
        byte_mask[b] = emask[b >> sew];
      end
    end
  end

endmodule

// File: rtl/v_merge_issue.sv
// Issue-side sequencer: takes one merge command, then splits the operation
// into DATA_WIDTH beats, producing address, byte select mask and tail enable.
module v_merge_issue
  import v_merge_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int VL_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [VL_WIDTH-1:0]   cmd_vl,
  input  logic [1:0]            cmd_sew,
  input  logic                  opd_valid,
  output logic                  opd_ready,
  input  logic [DATA_WIDTH-1:0] opd_vec0,
  input  logic [DATA_WIDTH-1:0] opd_vec1,
  input  logic [MASK_WIDTH-1:0] opd_emask,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [MASK_WIDTH-1:0] out_mask,
  output logic [MASK_WIDTH-1:0] out_be,
  output logic [DATA_WIDTH-1:0] out_vec0,
  output logic [DATA_WIDTH-1:0] out_vec1,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(MASK_WIDTH) + 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [VL_WIDTH-1:0]   rem_q;
  sew_t                  sew_q;

  logic                  cmd_hs, opd_hs, last;
  logic [CNT_W-1:0]      epb_cur, n;
  logic [MASK_WIDTH-1:0] beat_mask, beat_be;

  assign cmd_ready = (state == IDLE);
  assign opd_ready = (state == RUN);
  assign busy      = (state == RUN);
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign opd_hs    = opd_valid && opd_ready;

  // The beat that covers everything still outstanding closes the command.
  assign epb_cur = CNT_W'(epb(sew_q, MASK_WIDTH));
  assign last    = (rem_q <= VL_WIDTH'(epb_cur));
  assign n       = last ? rem_q[CNT_W-1:0] : epb_cur;

  v_mask_expand #(
    .MASK_WIDTH(MASK_WIDTH),
    .CNT_W     (CNT_W)
  ) u_mask_expand (
    .emask    (opd_emask),
    .sew      (sew_q),
    .n        (n),
    .byte_mask(beat_mask),
    .byte_en  (beat_be)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_hs && (cmd_vl != '0)) state_nxt = RUN;
      RUN:  if (opd_hs && last)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat outputs default to zero every cycle so idle cycles carry no data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      sew_q     <= SEW8;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_mask  <= '0;
      out_be    <= '0;
      out_vec0  <= '0;
      out_vec1  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_mask  <= '0;
      out_be    <= '0;
      out_vec0  <= '0;
      out_vec1  <= '0;
      done      <= 1'b0;
      if (cmd_hs) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_vl;
        sew_q  <= sew_t'(cmd_sew);
        done   <= (cmd_vl == '0);
      end
      if (opd_hs) begin
        out_valid <= 1'b1;
        out_addr  <= addr_q;
        out_mask  <= beat_mask;
        out_be    <= beat_be;
        out_vec0  <= opd_vec0;
        out_vec1  <= opd_vec1;
        addr_q    <= addr_q + 1'b1;
        rem_q     <= rem_q - VL_WIDTH'(n);
        done      <= last;
      end
    end
  end

endmodule

// File: tb/tb_v_merge_issue.sv
// Directed bench for v_merge_issue: hand-computed beats, tails, gaps,
// address wrap, mid-command reset and back-to-back commands.
module tb_v_merge_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_vl;
  logic [1:0]  cmd_sew;
  logic        opd_valid;
  logic        opd_ready;
  logic [63:0] opd_vec0, opd_vec1;
  logic [7:0]  opd_emask;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [7:0]  out_mask, out_be;
  logic [63:0] out_vec0, out_vec1;
  logic        busy, done;

  int total = 0;
  int bad   = 0;

  v_merge_issue dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_vl(cmd_vl), .cmd_sew(cmd_sew),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_vec0(opd_vec0),
    .opd_vec1(opd_vec1), .opd_emask(opd_emask),
    .out_valid(out_valid), .out_addr(out_addr), .out_mask(out_mask),
    .out_be(out_be), .out_vec0(out_vec0), .out_vec1(out_vec1),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_vl = '0; cmd_sew = '0;
    opd_valid = 1'b0; opd_vec0 = '0; opd_vec1 = '0; opd_emask = '0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_out_addr", out_addr, 0);
    checkOutput("rst_opd_ready", opd_ready, 0);
    rst = 1'b0;
    applyStimulus();
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    // Single full beat, SEW8
    cmd_valid = 1; cmd_addr = 32'h100; cmd_vl = 16'd8; cmd_sew = 2'd0;
    applyStimulus();
    cmd_valid = 0;
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_opd_ready", opd_ready, 1);
    checkOutput("t1_cmd_ready", cmd_ready, 0);
    checkOutput("t1_no_early_valid", out_valid, 0);
    opd_valid = 1; opd_emask = 8'hA5;
    opd_vec0 = 64'h1111_2222_3333_4444; opd_vec1 = 64'h5555_6666_7777_8888;
    applyStimulus();
    opd_valid = 0;
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_addr", out_addr, 64'h100);
    checkOutput("t1_mask", out_mask, 8'hA5);
    checkOutput("t1_be", out_be, 8'hFF);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_vec0", out_vec0, 64'h1111_2222_3333_4444);
    checkOutput("t1_vec1", out_vec1, 64'h5555_6666_7777_8888);
    checkOutput("t1_idle_after", busy, 0);
    applyStimulus();
    checkOutput("t1_valid_drop", out_valid, 0);
    checkOutput("t1_done_drop", done, 0);
    checkOutput("t1_vec0_zero", out_vec0, 0);

    // vl=5, SEW16: full beat then one-element tail
    cmd_valid = 1; cmd_addr = 32'h20; cmd_vl = 16'd5; cmd_sew = 2'd1;
    applyStimulus();
    cmd_valid = 0;
    opd_valid = 1; opd_emask = 8'h06;
    applyStimulus();
    checkOutput("t2_b0_valid", out_valid, 1);
    checkOutput("t2_b0_addr", out_addr, 64'h20);
    checkOutput("t2_b0_mask", out_mask, 8'h3C);
    checkOutput("t2_b0_be", out_be, 8'hFF);
    checkOutput("t2_b0_done", done, 0);
    checkOutput("t2_b0_busy", busy, 1);
    opd_emask = 8'h01;
    applyStimulus();
    opd_valid = 0;
    checkOutput("t2_b1_addr", out_addr, 64'h21);
    checkOutput("t2_b1_mask", out_mask, 8'h03);
    checkOutput("t2_b1_be", out_be, 8'h03);
    checkOutput("t2_b1_done", done, 1);

    // vl=0: done only, no beat
    applyStimulus();
    cmd_valid = 1; cmd_addr = 32'h40; cmd_vl = 16'd0; cmd_sew = 2'd0;
    applyStimulus();
    cmd_valid = 0;
    checkOutput("t3_done", done, 1);
    checkOutput("t3_valid", out_valid, 0);
    checkOutput("t3_cmd_ready", cmd_ready, 1);
    checkOutput("t3_busy", busy, 0);
    applyStimulus();
    checkOutput("t3_done_drop", done, 0);
    checkOutput("t3_valid_still0", out_valid, 0);

    // SEW64, address wrap, gapped operand stream
    cmd_valid = 1; cmd_addr = 32'hFFFF_FFFF; cmd_vl = 16'd3; cmd_sew = 2'd3;
    applyStimulus();
    cmd_valid = 0;
    opd_valid = 1; opd_emask = 8'h01;
    applyStimulus();
    checkOutput("t4_b0_valid", out_valid, 1);
    checkOutput("t4_b0_addr", out_addr, 64'hFFFF_FFFF);
    checkOutput("t4_b0_mask", out_mask, 8'hFF);
    checkOutput("t4_b0_be", out_be, 8'hFF);
    opd_valid = 0; opd_emask = 8'hFE;
    applyStimulus();
    checkOutput("t4_gap0_valid", out_valid, 0);
    checkOutput("t4_gap0_addr", out_addr, 0);
    opd_valid = 1; opd_emask = 8'hFE;
    applyStimulus();
    checkOutput("t4_b1_valid", out_valid, 1);
    checkOutput("t4_b1_addr", out_addr, 64'h0);
    checkOutput("t4_b1_mask", out_mask, 8'h00);
    checkOutput("t4_b1_be", out_be, 8'hFF);
    checkOutput("t4_b1_done", done, 0);
    opd_valid = 0;
    applyStimulus();
    checkOutput("t4_gap1_valid", out_valid, 0);
    checkOutput("t4_gap1_busy", busy, 1);
    opd_valid = 1; opd_emask = 8'h01;
    applyStimulus();
    opd_valid = 0;
    checkOutput("t4_b2_valid", out_valid, 1);
    checkOutput("t4_b2_addr", out_addr, 64'h1);
    checkOutput("t4_b2_mask", out_mask, 8'hFF);
    checkOutput("t4_b2_done", done, 1);

    // Reset in the middle of a long command
    applyStimulus();
    cmd_valid = 1; cmd_addr = 32'h40; cmd_vl = 16'd16; cmd_sew = 2'd0;
    applyStimulus();
    cmd_valid = 0;
    opd_valid = 1; opd_emask = 8'hFF;
    applyStimulus();
    checkOutput("t5_b0_addr", out_addr, 64'h40);
    checkOutput("t5_b0_done", done, 0);
    rst = 1;
    applyStimulus();
    rst = 0; opd_valid = 0;
    checkOutput("t5_rst_valid", out_valid, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_done", done, 0);
    applyStimulus();
    checkOutput("t5_no_done_late", done, 0);
    cmd_valid = 1; cmd_addr = 32'h300; cmd_vl = 16'd2; cmd_sew = 2'd0;
    applyStimulus();
    cmd_valid = 0;
    opd_valid = 1; opd_emask = 8'h02;
    applyStimulus();
    opd_valid = 0;
    checkOutput("t5_new_addr", out_addr, 64'h300);
    checkOutput("t5_new_mask", out_mask, 8'h02);
    checkOutput("t5_new_be", out_be, 8'h03);
    checkOutput("t5_new_done", done, 1);

    // Back-to-back commands, second offered during last-beat cycle
    applyStimulus();
    cmd_valid = 1; cmd_addr = 32'h500; cmd_vl = 16'd4; cmd_sew = 2'd2;
    applyStimulus();
    cmd_valid = 0;
    opd_valid = 1; opd_emask = 8'h01;
    applyStimulus();
    checkOutput("t6_b0_mask", out_mask, 8'h0F);
    checkOutput("t6_b0_be", out_be, 8'hFF);
    opd_emask = 8'h02;
    applyStimulus();
    checkOutput("t6_b1_addr", out_addr, 64'h501);
    checkOutput("t6_b1_mask", out_mask, 8'hF0);
    checkOutput("t6_b1_done", done, 1);
    checkOutput("t6_b1_cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_addr = 32'h600; cmd_vl = 16'd1; cmd_sew = 2'd0;
    opd_emask = 8'h01;
    applyStimulus();
    cmd_valid = 0;
    checkOutput("t6_c2_busy", busy, 1);
    checkOutput("t6_c2_no_beat", out_valid, 0);
    checkOutput("t6_c2_opd_ready", opd_ready, 1);
    applyStimulus();
    opd_valid = 0;
    checkOutput("t6_c2_valid", out_valid, 1);
    checkOutput("t6_c2_addr", out_addr, 64'h600);
    checkOutput("t6_c2_mask", out_mask, 8'h01);
    checkOutput("t6_c2_be", out_be, 8'h01);
    checkOutput("t6_c2_done", done, 1);
    applyStimulus();
    checkOutput("t6_final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
